// File: rtl/fir_pkg.sv
// Shared FIR stream constants: default data/counter widths and the
// buffered {tlast, tdata} entry layout used by the FIR and its output buffer.
package fir_pkg;
  localparam int FIR_DATA_W  = 32;
  localparam int FIR_CNT_W   = 10;
  localparam int FIR_ENTRY_W = FIR_DATA_W + 1;

  typedef struct packed {
    logic                  last;
    logic [FIR_DATA_W-1:0] data;
  } fir_beat_t;
endpackage

// File: rtl/fir_out_buffer_if.sv
// AXI-Stream beat bundle (valid/ready/data/last) with master and slave views.
interface fir_out_buffer_if
  import fir_pkg::*;
#(
  parameter int DW = FIR_DATA_W
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;

  modport master (output tvalid, output tdata, output tlast, input  tready);
  modport slave  (input  tvalid, input  tdata, input  tlast, output tready);
endinterface

// File: rtl/fir_out_ram.sv
// FIFO storage: register array with synchronous write and combinational read.
module fir_out_ram #(
  parameter  int pDEPTH = 8,
  parameter  int pWIDTH = 33,
  localparam int AW     = $clog2(pDEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [pWIDTH-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [pWIDTH-1:0] rdata_o
);
  logic [pWIDTH-1:0] mem_q [pDEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fir_out_buffer.sv
// Output-side AXI-Stream elastic FIFO behind the FIR; counts egress beats
// per frame and reports the completed frame length when tlast leaves.
module fir_out_buffer
  import fir_pkg::*;
#(
  parameter  int pDATA_WIDTH = FIR_DATA_W,
  parameter  int pDEPTH      = 8,
  parameter  int pCNT_WIDTH  = FIR_CNT_W,
  localparam int AW          = $clog2(pDEPTH),
  localparam int LW          = AW + 1
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst,
  fir_out_buffer_if.slave       s,
  fir_out_buffer_if.master      m,
  output logic [LW-1:0]         level,
  output logic [pCNT_WIDTH-1:0] frame_len,
  output logic                  frame_done
);
  localparam int EW = pDATA_WIDTH + 1;

  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [pCNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d, frame_len_q, frame_len_d, beat_inc;
  logic                  done_q, done_d;
  logic                  rdy_q;
  logic                  full, empty, push, pop, pop_last;
  logic [EW-1:0]         rd_entry;

  assign full  = (level_q == LW'(pDEPTH));
  assign empty = (level_q == '0);

  // rdy_q holds tready low until the first edge after reset release
  assign s.tready = rdy_q & ~full;
  assign m.tvalid = ~empty;
  assign {m.tlast, m.tdata} = empty ? '0 : rd_entry;

  assign push     = s.tvalid & rdy_q & ~full;
  assign pop      = ~empty & m.tready;
  assign pop_last = pop & rd_entry[pDATA_WIDTH];
  assign beat_inc = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + 1'b1;

  fir_out_ram #(.pDEPTH(pDEPTH), .pWIDTH(EW)) u_ram (
    .clk_i   (axis_clk),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i ({s.tlast, s.tdata}),
    .raddr_i (rptr_q),
    .rdata_o (rd_entry)
  );

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    level_d     = level_q;
    beat_cnt_d  = beat_cnt_q;
    frame_len_d = frame_len_q;
    done_d      = pop_last;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (pop_last) begin
      frame_len_d = beat_inc;
      beat_cnt_d  = '0;
    end else if (pop) begin
      beat_cnt_d  = beat_inc;
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      beat_cnt_q  <= '0;
      frame_len_q <= '0;
      done_q      <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      beat_cnt_q  <= beat_cnt_d;
      frame_len_q <= frame_len_d;
      done_q      <= done_d;
      rdy_q       <= 1'b1;
    end
  end

  assign level      = level_q;
  assign frame_len  = frame_len_q;
  assign frame_done = done_q;
endmodule
